// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, issues single word reads, and buffers one returned word for decode.
// Latency: request one edge after fetch is allowed; instr_valid one edge after mem_ack.
// Backpressure: instr_ready low holds the buffered word and blocks new requests; stall/fetch_en gate only new requests.
module fetch_unit #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] PC_INCR      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_en,
    input  logic                         stall,
    input  logic                         branch_valid,
    input  logic [ADDRESS_BUS_WIDTH-1:0] branch_target,
    output logic                         mem_req,
    output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
    input  logic                         mem_ack,
    input  logic [DATA_BUS_WIDTH-1:0]    mem_rdata,
    output logic                         instr_valid,
    output logic [DATA_BUS_WIDTH-1:0]    instr,
    output logic [ADDRESS_BUS_WIDTH-1:0] instr_pc,
    input  logic                         instr_ready,
    output logic [ADDRESS_BUS_WIDTH-1:0] pc
);

    // One-hot so the request and valid outputs each come straight off a flop.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        REQ  = 3'b010,
        HOLD = 3'b100
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   squash;

    logic                         fetch_ok;
    logic [ADDRESS_BUS_WIDTH-1:0] fetch_addr;
    logic                         ack_take;
    logic                         ack_keep;
    logic                         issue;

    assign fetch_ok   = fetch_en && !stall;
    // A redirect in the same cycle as a new request must already point the request at the target.
    assign fetch_addr = branch_valid ? branch_target : pc;
    assign ack_take   = (state == REQ) && mem_ack;
    // Returned word is kept only if no redirect happened while it was in flight or on its ack cycle.
    assign ack_keep   = ack_take && !squash && !branch_valid;
    // A fresh request starts whenever we enter REQ, including re-entry straight from a discarded ack.
    assign issue      = (state_nxt == REQ) && ((state != REQ) || mem_ack);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: an outstanding read always runs to its ack; HOLD leaves on accept or flush.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fetch_ok) state_nxt = REQ;
            end
            REQ: begin
                if (mem_ack) begin
                    if (squash || branch_valid) state_nxt = fetch_ok ? REQ : IDLE;
                    else                        state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready || branch_valid) state_nxt = fetch_ok ? REQ : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        mem_req     = (state == REQ);
        instr_valid = (state == HOLD);
    end

    // PC, request address, output buffer and squash flag; a branch always wins over the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_VECTOR;
            mem_addr <= RESET_VECTOR;
            instr    <= '0;
            instr_pc <= '0;
            squash   <= 1'b0;
        end else begin
            if (branch_valid)  pc <= branch_target;
            else if (ack_keep) pc <= pc + PC_INCR;

            if (issue) mem_addr <= fetch_addr;

            if (ack_keep) begin
                instr    <= mem_rdata;
                instr_pc <= mem_addr;
            end

            if (ack_take)                          squash <= 1'b0;
            else if ((state == REQ) && branch_valid) squash <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural memory responder plus an address/PC model
// that predicts which words must reach decode, at what address, and in what order.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        stall;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic [15:0] pc;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mem_seed;
    logic [15:0] m_pc;
    int          lat;
    int          cnt;
    int          inj_req;
    int          inj_done;
    logic [15:0] inj_data;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .pc(pc)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ mem_seed;
    endfunction

    // Memory: acks after 'lat' waiting cycles of mem_req; can also emit a stray ack on demand.
    initial begin
        mem_ack = 1'b0; mem_rdata = '0; cnt = 0; inj_done = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_ack) begin
                mem_ack = 1'b0; cnt = 0;
            end else if (inj_req != inj_done) begin
                mem_ack = 1'b1; mem_rdata = inj_data; inj_done++;
            end else if (mem_req) begin
                if (cnt >= lat) begin mem_ack = 1'b1; mem_rdata = mem_word(mem_addr); end
                else cnt++;
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; fetch_en = 1'b0; stall = 1'b0; branch_valid = 1'b0;
        branch_target = '0; instr_ready = 1'b0; lat = 0;
        tick(); tick();
        rst = 1'b0; m_pc = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b1; stall = 1'b0; branch_valid = 1'b1;
        branch_target = 16'($urandom); instr_ready = 1'b1; lat = 0;
        tick(); tick();
        n_checks++;
        if ({pc, mem_addr, mem_req, instr_valid, instr, instr_pc} !== {16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0}) begin
            n_errors++;
            $display("FAIL reset_state: got pc=%h addr=%h req=%b vld=%b instr=%h ipc=%h expected all zero",
                     pc, mem_addr, mem_req, instr_valid, instr, instr_pc);
        end
        rst = 1'b0; branch_valid = 1'b0; fetch_en = 1'b0; m_pc = 16'h0000;
    endtask

    // Runs until n words have been handed to decode, checking every request and delivery.
    task automatic test_stream(input string tag, input int n, input bit rnd);
        int got;
        logic req_b, ack_b, v_b, r_b;
        logic [15:0] held_i, held_pc;
        got = 0;
        for (int cyc = 0; cyc < n * 12 + 20 && got < n; cyc++) begin
            if (rnd) begin
                lat = $urandom_range(0, 3);
                instr_ready = ($urandom_range(0, 2) != 0);
                stall = ($urandom_range(0, 3) == 0);
            end
            req_b = mem_req; ack_b = mem_ack; v_b = instr_valid; r_b = instr_ready;
            held_i = instr; held_pc = instr_pc;
            tick();
            if (mem_req && (!req_b || ack_b)) begin
                n_checks++;
                if (mem_addr !== m_pc) begin
                    n_errors++; $display("FAIL %s_req_addr: got %h expected %h", tag, mem_addr, m_pc);
                end
            end
            if (req_b && ack_b) begin
                n_checks++;
                if ({instr_valid, instr_pc, instr, pc} !== {1'b1, m_pc, mem_word(m_pc), m_pc + 16'd1}) begin
                    n_errors++;
                    $display("FAIL %s_deliver: got vld=%b ipc=%h instr=%h pc=%h expected vld=1 ipc=%h instr=%h pc=%h",
                             tag, instr_valid, instr_pc, instr, pc, m_pc, mem_word(m_pc), m_pc + 16'd1);
                end
                m_pc = m_pc + 16'd1;
            end
            if (v_b && r_b) begin
                got++;
                n_checks++;
                if (instr_valid !== 1'b0) begin
                    n_errors++; $display("FAIL %s_handshake: instr_valid=%b expected 0", tag, instr_valid);
                end
            end else if (v_b) begin
                n_checks++;
                if ({instr_valid, instr, instr_pc} !== {1'b1, held_i, held_pc}) begin
                    n_errors++;
                    $display("FAIL %s_hold_stable: got vld=%b instr=%h ipc=%h expected 1 %h %h",
                             tag, instr_valid, instr, instr_pc, held_i, held_pc);
                end
            end
            n_checks++;
            if (mem_req && instr_valid) begin
                n_errors++; $display("FAIL %s_req_in_hold: mem_req=%b instr_valid=%b expected not both", tag, mem_req, instr_valid);
            end
        end
        n_checks++;
        if (got != n) begin
            n_errors++; $display("FAIL %s_timeout: delivered %0d expected %0d", tag, got, n);
        end
        stall = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        lat = 1; instr_ready = 1'b1; fetch_en = 1'b1;
        tick();
        n_checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
            n_errors++; $display("FAIL req_latency: got req=%b addr=%h expected 1 0000", mem_req, mem_addr);
        end
        test_stream("seq", 4, 1'b0);
        n_checks++;
        if (pc !== 16'd4) begin
            n_errors++; $display("FAIL seq_pc: got %h expected 0004", pc);
        end
    endtask

    task automatic test_random();
        do_reset();
        fetch_en = 1'b1;
        test_stream("rand", 40, 1'b1);
    endtask

    task automatic test_stall_idle();
        logic [15:0] tgt;
        do_reset();
        tgt = 16'($urandom);
        branch_valid = 1'b1; branch_target = tgt;
        tick();
        branch_valid = 1'b0; m_pc = tgt;
        n_checks++;
        if ({pc, mem_req} !== {m_pc, 1'b0}) begin
            n_errors++; $display("FAIL idle_branch: got pc=%h req=%b expected %h 0", pc, mem_req, m_pc);
        end
        fetch_en = 1'b1; stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin inj_data = 16'hBEEF; inj_req++; end
            tick();
            n_checks++;
            if ({mem_req, instr_valid, pc} !== {1'b0, 1'b0, m_pc}) begin
                n_errors++;
                $display("FAIL stall_idle: got req=%b vld=%b pc=%h expected 0 0 %h", mem_req, instr_valid, pc, m_pc);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if ({mem_req, mem_addr} !== {1'b1, m_pc}) begin
            n_errors++; $display("FAIL stall_release: got req=%b addr=%h expected 1 %h", mem_req, mem_addr, m_pc);
        end
    endtask

    task automatic test_hold();
        logic [15:0] held_i, held_pc;
        do_reset();
        lat = $urandom_range(0, 2); fetch_en = 1'b1; instr_ready = 1'b0;
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0000, mem_word(16'h0000)}) begin
            n_errors++;
            $display("FAIL hold_first: got vld=%b ipc=%h instr=%h expected 1 0000 %h", instr_valid, instr_pc, instr, mem_word(16'h0000));
        end
        held_i = instr; held_pc = instr_pc;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin inj_data = ~held_i; inj_req++; end
            tick();
            n_checks++;
            if ({instr_valid, instr, instr_pc, mem_req, pc} !== {1'b1, held_i, held_pc, 1'b0, 16'd1}) begin
                n_errors++;
                $display("FAIL hold_stable: got vld=%b instr=%h ipc=%h req=%b pc=%h expected 1 %h %h 0 0001",
                         instr_valid, instr, instr_pc, mem_req, pc, held_i, held_pc);
            end
        end
        instr_ready = 1'b1;
        tick();
        n_checks++;
        if ({instr_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 16'd1}) begin
            n_errors++;
            $display("FAIL hold_release: got vld=%b req=%b addr=%h expected 0 1 0001", instr_valid, mem_req, mem_addr);
        end
    endtask

    // Redirect while the read is still waiting: the late word must be dropped.
    task automatic test_branch_req(input logic [15:0] tgt);
        logic req_b, ack_b;
        bit seen_new, done;
        do_reset();
        lat = 3; fetch_en = 1'b1; instr_ready = 1'b1;
        tick(); tick();
        branch_valid = 1'b1; branch_target = tgt;
        tick();
        branch_valid = 1'b0;
        n_checks++;
        if ({pc, mem_req, mem_addr} !== {tgt, 1'b1, 16'h0000}) begin
            n_errors++;
            $display("FAIL br_req_pc: got pc=%h req=%b addr=%h expected %h 1 0000", pc, mem_req, mem_addr, tgt);
        end
        seen_new = 0; done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            req_b = mem_req; ack_b = mem_ack;
            tick();
            if (!seen_new && mem_req && req_b && !ack_b) begin
                n_checks++;
                if (mem_addr !== 16'h0000) begin
                    n_errors++; $display("FAIL br_req_stable: got addr=%h expected 0000", mem_addr);
                end
            end
            if (!seen_new && mem_req && (!req_b || ack_b)) begin
                seen_new = 1;
                n_checks++;
                if (mem_addr !== tgt) begin
                    n_errors++; $display("FAIL br_req_next: got addr=%h expected %h", mem_addr, tgt);
                end
            end
            if (instr_valid) begin
                done = 1;
                n_checks++;
                if ({instr_pc, instr, pc} !== {tgt, mem_word(tgt), tgt + 16'd1}) begin
                    n_errors++;
                    $display("FAIL br_req_deliver: got ipc=%h instr=%h pc=%h expected %h %h %h",
                             instr_pc, instr, pc, tgt, mem_word(tgt), tgt + 16'd1);
                end
            end
        end
        n_checks++;
        if (!done) begin
            n_errors++; $display("FAIL br_req_timeout: instr_valid=%b expected 1", instr_valid);
        end
    endtask

    // Redirect to 0x0010 on the ack cycle (in_hold=0) or while holding a word (in_hold=1).
    task automatic test_branch_flush(input bit in_hold, input bit rdy);
        do_reset();
        lat = in_hold ? 0 : $urandom_range(1, 3);
        fetch_en = 1'b1; instr_ready = in_hold ? 1'b0 : 1'b1;
        if (in_hold) for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        else         for (int i = 0; i < 20 && mem_ack !== 1'b1; i++) tick();
        n_checks++;
        if ((in_hold ? instr_valid : mem_ack) !== 1'b1) begin
            n_errors++; $display("FAIL br_flush_wait: got vld=%b ack=%b expected event", instr_valid, mem_ack);
        end
        if (in_hold) instr_ready = rdy;
        branch_valid = 1'b1; branch_target = 16'h0010;
        tick();
        branch_valid = 1'b0; instr_ready = 1'b1;
        n_checks++;
        if ({instr_valid, pc, mem_req, mem_addr} !== {1'b0, 16'h0010, 1'b1, 16'h0010}) begin
            n_errors++;
            $display("FAIL br_flush_redirect: got vld=%b pc=%h req=%b addr=%h expected 0 0010 1 0010",
                     instr_valid, pc, mem_req, mem_addr);
        end
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0010, mem_word(16'h0010)}) begin
            n_errors++;
            $display("FAIL br_flush_deliver: got vld=%b ipc=%h instr=%h expected 1 0010 %h",
                     instr_valid, instr_pc, instr, mem_word(16'h0010));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        branch_valid = 1'b1; branch_target = 16'hFFFF;
        tick();
        branch_valid = 1'b0; fetch_en = 1'b1; lat = 0; instr_ready = 1'b0;
        tick();
        n_checks++;
        if ({pc, mem_req, mem_addr} !== {16'hFFFF, 1'b1, 16'hFFFF}) begin
            n_errors++; $display("FAIL wrap_req: got pc=%h req=%b addr=%h expected ffff 1 ffff", pc, mem_req, mem_addr);
        end
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        n_checks++;
        if ({instr_valid, instr_pc, instr, pc} !== {1'b1, 16'hFFFF, mem_word(16'hFFFF), 16'h0000}) begin
            n_errors++;
            $display("FAIL wrap_pc: got vld=%b ipc=%h instr=%h pc=%h expected 1 ffff %h 0000",
                     instr_valid, instr_pc, instr, pc, mem_word(16'hFFFF));
        end
        instr_ready = 1'b1;
        tick();
        n_checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
            n_errors++; $display("FAIL wrap_next: got req=%b addr=%h expected 1 0000", mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        lat = 0; fetch_en = 1'b1; instr_ready = 1'b0;
        for (int i = 0; i < 20 && instr_valid !== 1'b1; i++) tick();
        lat = 6; instr_ready = 1'b1;
        tick();
        n_checks++;
        if ({mem_req, mem_addr, instr} !== {1'b1, 16'd1, mem_word(16'h0000)}) begin
            n_errors++;
            $display("FAIL rst_mid_pre: got req=%b addr=%h instr=%h expected 1 0001 %h", mem_req, mem_addr, instr, mem_word(16'h0000));
        end
        tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if ({pc, mem_addr, mem_req, instr_valid, instr, instr_pc} !== {16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0}) begin
            n_errors++;
            $display("FAIL rst_mid_req: got pc=%h addr=%h req=%b vld=%b instr=%h ipc=%h expected all zero",
                     pc, mem_addr, mem_req, instr_valid, instr, instr_pc);
        end
        rst = 1'b0; fetch_en = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_seed = 16'($urandom) | 16'h0001;
        inj_req = 0; inj_data = '0; lat = 0;
        test_reset();
        test_sequential();
        test_stall_idle();
        test_hold();
        test_branch_req(16'h0040);
        test_branch_req(16'($urandom_range(16, 16'hFFF0)));
        test_branch_flush(1'b0, 1'b1);
        test_branch_flush(1'b1, 1'b1);
        test_branch_flush(1'b1, 1'b0);
        test_wrap();
        test_random();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage holding the program counter. It issues one-at-a-time word reads to instruction memory over a req/ack handshake and buffers the returned word in a one-entry valid/ready output register for decode. Its `mem_addr` output is the PC-side input of the CPU's address-select mux, and its `instr` output feeds the data path. Branch redirects are accepted in any state: an in-flight read is completed and then squashed, and a buffered instruction is flushed.

## Interface
- `ADDRESS_BUS_WIDTH`, 16, width of PC and memory address (value taken from params.v)
- `DATA_BUS_WIDTH`, 16, width of instruction word (value taken from params.v)
- `RESET_VECTOR`, 0, PC value loaded on reset
- `PC_INCR`, 1, PC increment per fetched word (word-addressed memory)

- `clk` in 1: single clock; all state updates on the rising edge
- `rst` in 1: synchronous, active-high reset
- `fetch_en` in 1: permission to start new fetches
- `stall` in 1: blocks starting a new fetch; never aborts an outstanding one
- `branch_valid` in 1: redirect PC this cycle
- `branch_target` in ADDRESS_BUS_WIDTH: redirect address
- `mem_req` out 1: read request, registered
- `mem_addr` out ADDRESS_BUS_WIDTH: read address, registered
- `mem_ack` in 1: one-cycle read completion; `mem_rdata` valid in the same cycle
- `mem_rdata` in DATA_BUS_WIDTH: read data
- `instr_valid` out 1: output buffer holds an instruction
- `instr` out DATA_BUS_WIDTH: buffered instruction
- `instr_pc` out ADDRESS_BUS_WIDTH: address `instr` was fetched from
- `instr_ready` in 1: consumer accepts; the transfer occurs when `instr_valid && instr_ready`
- `pc` out ADDRESS_BUS_WIDTH: next fetch address (PC register)

## Operation
- States:
  - IDLE: no request, buffer empty.
  - REQ: `mem_req`=1, waiting for `mem_ack`.
  - HOLD: `instr_valid`=1, waiting for `instr_ready`.
- IDLE → REQ when `fetch_en && !stall`. On entry, `mem_addr` is set to `pc`.
- REQ:
  - `mem_addr` and `mem_req` stay stable until `mem_ack`.
  - On `mem_ack` with no squash pending and no `branch_valid`:
    - `instr` ← `mem_rdata`
    - `instr_pc` ← `mem_addr`
    - `instr_valid` ← 1
    - `pc` ← `pc` + `PC_INCR` (mod 2^ADDRESS_BUS_WIDTH; wraps from all-ones to 0)
    - go to HOLD.
- HOLD, on `instr_ready`: `instr_valid` ← 0. Then go to REQ (with `mem_addr` ← `pc`) if `fetch_en && !stall`, else IDLE.
- `branch_valid` sets `pc` ← `branch_target` in every state and takes priority over increment. Further rules by state:
  - IDLE: no further action.
  - REQ without `mem_ack`: set the `squash` flag. `mem_req`/`mem_addr` are unchanged. The later ack's data is discarded, `squash` is cleared, and the state goes to REQ (new address = `pc`) if `fetch_en && !stall`, else IDLE. `pc` is not incremented.
  - REQ with `mem_ack` in the same cycle: data discarded, same exit as the squash case.
  - HOLD: `instr_valid` ← 0 (flush, whether or not `instr_ready` is high). Exit as in the HOLD rule above.
- A branch arriving while `squash` is already set only updates `pc` (last target wins).
- `mem_ack` outside REQ is ignored.
- `stall`/`fetch_en` low during REQ or HOLD has no effect on the current transaction.

## Timing
- Reset values (edge with `rst`=1): IDLE, `squash`=0, `pc`=`RESET_VECTOR`, `mem_addr`=`RESET_VECTOR`, `mem_req`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0.
- `rst` has priority over all inputs and abandons any outstanding request; memory must tolerate a dropped request.
- Request latency: `fetch_en` sampled high in IDLE at edge k → `mem_req`=1 after edge k.
- Ack latency: `mem_ack` at edge n → `instr_valid`=1 after edge n.
- Handshake: `instr_ready` at edge m → `instr_valid`=0 after m. If fetch is allowed, `mem_req`=1 after m.
- Peak throughput: one instruction per 2 cycles plus memory latency.
- Branch effect: visible on `pc` one edge after `branch_valid`. The first request to the target is issued no earlier than the edge that retires the squashed ack.

## Test plan
- Reset, then `fetch_en`=1, memory acks 1 cycle after req, `instr_ready`=1 → requests to 0,1,2,3; `instr`/`instr_pc` pairs match memory words 0–3; `pc`=4 after the fourth ack.
- `stall`=1 for 5 cycles in IDLE → `mem_req` stays 0. Release → `mem_req`=1 next cycle with `mem_addr`=current `pc`.
- Hold `instr_ready`=0 for 4 cycles in HOLD → `instr`/`instr_pc` stable and `mem_req`=0 throughout. Then `instr_ready`=1 → next request issues.
- Branch to 0x0040 while REQ is waiting (ack 3 cycles later) → returned word never appears as `instr_valid`; next `mem_addr`=0x0040; `pc`=0x0041 after its ack.
- Branch to 0x0010 in the ack cycle, and separately in HOLD with `instr_ready`=1 → no valid output of the old word after that edge; the next fetch is from 0x0010.
- `pc`=0xFFFF at ack (16-bit) → `pc` wraps to 0x0000. Assert `rst` mid-REQ → all outputs return to their reset values next cycle.
